execution_mc: RTL and testbench
===============================

Name: execution_mc

Overview:
- Parametrised next-generation EX stage for the 5-stage MIPS pipeline, sitting between the DX and XM pipeline registers.
- Extends the single-cycle ALU/branch stage with:
  - a wider opcode set, including signed/unsigned compare, nor and xor;
  - an iterative multi-cycle multiplier that stalls upstream through a busy handshake;
  - a valid bit and a flush input for branch squashing.
- All XM outputs are registered.

Parameters:
- DW, 32, datapath width of A, B, NPC, ALUout, XM_BT, XM_MD
- IMMW, 16, immediate width; sign-extended to DW, then shifted left 2 for branch target
- RW, 5, destination register index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- DX_valid  in  1  instruction present in DX register
- flush  in  1  squash: drops incoming instruction and aborts a multiply in progress
- DX_MemtoReg, DX_RegWrite, DX_MemRead, DX_MemWrite, DX_branch  in  1 each  control bits from decode
- ALUctr  in  4  operation select (encoding below)
- NPC  in  DW  PC+4 of the instruction
- A, B  in  DW  operands
- imm  in  IMMW  branch offset (words)
- DX_RD  in  RW  destination register
- DX_MD  in  DW  store data
- ex_busy  out  1  high while the multiplier runs; upstream must hold DX inputs stable
- XM_valid  out  1  XM register holds a real instruction
- XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, XM_branch  out  1 each  registered control; XM_branch = branch taken
- ALUout  out  DW  result
- XM_BT  out  DW  branch target
- XM_RD  out  RW  destination register
- XM_MD  out  DW  store data

Behaviour:
- Reset (rst=0, asynchronous): every output is 0; state=IDLE; multiplier counter, accumulator and operand registers are 0.
- ALUctr encoding; any other code gives ALUout=0:
  - 0 add A+B
  - 1 sub A-B
  - 2 and
  - 3 or
  - 4 slt, signed, result 1/0
  - 5 beq, ALUout=0
  - 6 bne, ALUout=0
  - 7 nor
  - 8 xor
  - 9 sltu, unsigned
  - 10 mul, low DW bits of A*B, multi-cycle
- Arithmetic: add/sub wrap modulo 2^DW.
- Branch target: XM_BT = NPC + (sext(imm) << 2), truncated to DW; computed for every accepted instruction.
- XM_branch = DX_branch & ((ALUctr==5 & A==B) | (ALUctr==6 & A!=B)).
- State machine IDLE/MUL; ex_busy = (state==MUL), combinational from state.
- IDLE, each edge:
  - Accept when DX_valid & !flush. Non-mul op: load all XM outputs from DX/ALU, XM_valid=1. Latency is 1 cycle.
  - Accept of mul (ALUctr==10): latch A, B and all DX controls/RD/MD into holding registers; clear accumulator; cnt=0; go to MUL. Same edge writes a bubble.
  - No accept (DX_valid=0 or flush=1): write a bubble.
- Bubble: XM_valid=0; all five XM control bits 0; ALUout/XM_BT/XM_RD/XM_MD hold their previous values.
- MUL: one shift-add step per edge, using the latched operands (DX inputs are ignored).
  - On the edge where cnt==DW-1: write the final product to ALUout, load the latched controls/RD/MD, XM_valid=1, XM_branch=0, go to IDLE.
  - Other edges: cnt+1, write a bubble.
  - Accepted at edge E0 → result visible after edge E0+DW; ex_busy high exactly DW cycles.
  - No new instruction is accepted on the completing edge; the next one is accepted on the following edge at the earliest.
- flush=1 in MUL: abort; go to IDLE, write a bubble, discard the product. flush has priority over completion on the same edge.
- Reset mid-multiply: immediate return to the reset state; no partial result is ever visible.

Test Plan (DW=32):
- Reset held, then released → all outputs 0, ex_busy=0. Then add A=5 B=7 RD=3 RegWrite=1 → next cycle ALUout=12, XM_RD=3, XM_RegWrite=1, XM_valid=1.
- slt A=0xFFFFFFFF B=1 → ALUout=1. sltu same operands → ALUout=0. nor A=0 B=0 → 0xFFFFFFFF.
- beq A=B=9, DX_branch=1, NPC=0x100, imm=0xFFFF → XM_branch=1, XM_BT=0x000000FC. bne same operands → XM_branch=0.
- mul A=0x00010003 B=7 RD=8 → ex_busy high 32 cycles with XM_valid=0; then ALUout=0x00070015, XM_RD=8, XM_valid=1. A DX add presented during the busy window is accepted only after ex_busy falls.
- flush at cycle 10 of a mul → next cycle ex_busy=0, XM_valid=0, ALUout unchanged. Flush with DX_valid on an add → bubble.
- rst pulsed low mid-mul (cycle 5) → outputs 0 asynchronously, ex_busy=0; a subsequent add behaves normally.

Source files
------------

// File: rtl/execution_mc.sv
// rtl/execution_mc.sv - EX stage: ALU, branch resolve and iterative multiplier feeding the XM register
module execution_mc #(
    parameter int DW   = 32,
    parameter int IMMW = 16,
    parameter int RW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            DX_valid,
    input  logic            flush,
    input  logic            DX_MemtoReg,
    input  logic            DX_RegWrite,
    input  logic            DX_MemRead,
    input  logic            DX_MemWrite,
    input  logic            DX_branch,
    input  logic [3:0]      ALUctr,
    input  logic [DW-1:0]   NPC,
    input  logic [DW-1:0]   A,
    input  logic [DW-1:0]   B,
    input  logic [IMMW-1:0] imm,
    input  logic [RW-1:0]   DX_RD,
    input  logic [DW-1:0]   DX_MD,
    output logic            ex_busy,
    output logic            XM_valid,
    output logic            XM_MemtoReg,
    output logic            XM_RegWrite,
    output logic            XM_MemRead,
    output logic            XM_MemWrite,
    output logic            XM_branch,
    output logic [DW-1:0]   ALUout,
    output logic [DW-1:0]   XM_BT,
    output logic [RW-1:0]   XM_RD,
    output logic [DW-1:0]   XM_MD
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_BEQ  = 4'd5;
    localparam logic [3:0] OP_BNE  = 4'd6;
    localparam logic [3:0] OP_NOR  = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    typedef enum logic {IDLE, MUL} state_t;

    state_t state, state_nxt;

    logic [DW-1:0] mul_a, mul_b, acc;
    logic [CW-1:0] cnt;
    logic          h_memtoreg, h_regwrite, h_memread, h_memwrite;
    logic [RW-1:0] h_rd;
    logic [DW-1:0] h_md;

    logic          accept, is_mul, mul_last;
    logic [DW-1:0] alu_result, branch_target, acc_next;
    logic          branch_taken;

    assign accept   = DX_valid & ~flush;
    assign is_mul   = (ALUctr == OP_MUL);
    assign mul_last = (cnt == CW'(DW - 1));

    always_comb begin
        alu_result = '0;
        case (ALUctr)
            OP_ADD:  alu_result = A + B;
            OP_SUB:  alu_result = A - B;
            OP_AND:  alu_result = A & B;
            OP_OR:   alu_result = A | B;
            OP_SLT:  alu_result = ($signed(A) < $signed(B)) ? DW'(1) : '0;
            OP_NOR:  alu_result = ~(A | B);
            OP_XOR:  alu_result = A ^ B;
            OP_SLTU: alu_result = (A < B) ? DW'(1) : '0;
            default: alu_result = '0;
        endcase
    end

    assign branch_target = NPC + ({{(DW-IMMW){imm[IMMW-1]}}, imm} << 2);
    assign branch_taken  = DX_branch & (((ALUctr == OP_BEQ) & (A == B)) |
                                        ((ALUctr == OP_BNE) & (A != B)));

    // One shift-add step: multiplicand shifts left while multiplier shifts right.
    assign acc_next = acc + (mul_b[0] ? mul_a : '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && is_mul) state_nxt = MUL;
            MUL:  if (flush || mul_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ex_busy = (state == MUL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_a       <= '0;
            mul_b       <= '0;
            acc         <= '0;
            cnt         <= '0;
            h_memtoreg  <= 1'b0;
            h_regwrite  <= 1'b0;
            h_memread   <= 1'b0;
            h_memwrite  <= 1'b0;
            h_rd        <= '0;
            h_md        <= '0;
            XM_valid    <= 1'b0;
            XM_MemtoReg <= 1'b0;
            XM_RegWrite <= 1'b0;
            XM_MemRead  <= 1'b0;
            XM_MemWrite <= 1'b0;
            XM_branch   <= 1'b0;
            ALUout      <= '0;
            XM_BT       <= '0;
            XM_RD       <= '0;
            XM_MD       <= '0;
        end else begin
            // Bubble by default; data fields hold unless overwritten below.
            XM_valid    <= 1'b0;
            XM_MemtoReg <= 1'b0;
            XM_RegWrite <= 1'b0;
            XM_MemRead  <= 1'b0;
            XM_MemWrite <= 1'b0;
            XM_branch   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            mul_a      <= A;
                            mul_b      <= B;
                            acc        <= '0;
                            cnt        <= '0;
                            h_memtoreg <= DX_MemtoReg;
                            h_regwrite <= DX_RegWrite;
                            h_memread  <= DX_MemRead;
                            h_memwrite <= DX_MemWrite;
                            h_rd       <= DX_RD;
                            h_md       <= DX_MD;
                        end else begin
                            XM_valid    <= 1'b1;
                            XM_MemtoReg <= DX_MemtoReg;
                            XM_RegWrite <= DX_RegWrite;
                            XM_MemRead  <= DX_MemRead;
                            XM_MemWrite <= DX_MemWrite;
                            XM_branch   <= branch_taken;
                            ALUout      <= alu_result;
                            XM_BT       <= branch_target;
                            XM_RD       <= DX_RD;
                            XM_MD       <= DX_MD;
                        end
                    end
                end
                MUL: begin
                    if (flush) begin
                        cnt <= '0;
                    end else if (mul_last) begin
                        XM_valid    <= 1'b1;
                        XM_MemtoReg <= h_memtoreg;
                        XM_RegWrite <= h_regwrite;
                        XM_MemRead  <= h_memread;
                        XM_MemWrite <= h_memwrite;
                        ALUout      <= acc_next;
                        XM_RD       <= h_rd;
                        XM_MD       <= h_md;
                        cnt         <= '0;
                    end else begin
                        acc   <= acc_next;
                        mul_a <= mul_a << 1;
                        mul_b <= mul_b >> 1;
                        cnt   <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_execution_mc.sv
// tb/tb_execution_mc.sv - scoreboard bench for execution_mc
module tb_execution_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        DX_valid = 1'b0, flush = 1'b0;
    logic        DX_MemtoReg = 1'b0, DX_RegWrite = 1'b0, DX_MemRead = 1'b0;
    logic        DX_MemWrite = 1'b0, DX_branch = 1'b0;
    logic [3:0]  ALUctr = '0;
    logic [31:0] NPC = '0, A = '0, B = '0, DX_MD = '0;
    logic [15:0] imm = '0;
    logic [4:0]  DX_RD = '0;
    logic        ex_busy, XM_valid, XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, XM_branch;
    logic [31:0] ALUout, XM_BT, XM_MD;
    logic [4:0]  XM_RD;

    execution_mc #(.DW(32), .IMMW(16), .RW(5)) dut (
        .clk(clk), .rst(rst), .DX_valid(DX_valid), .flush(flush),
        .DX_MemtoReg(DX_MemtoReg), .DX_RegWrite(DX_RegWrite), .DX_MemRead(DX_MemRead),
        .DX_MemWrite(DX_MemWrite), .DX_branch(DX_branch), .ALUctr(ALUctr),
        .NPC(NPC), .A(A), .B(B), .imm(imm), .DX_RD(DX_RD), .DX_MD(DX_MD),
        .ex_busy(ex_busy), .XM_valid(XM_valid), .XM_MemtoReg(XM_MemtoReg),
        .XM_RegWrite(XM_RegWrite), .XM_MemRead(XM_MemRead), .XM_MemWrite(XM_MemWrite),
        .XM_branch(XM_branch), .ALUout(ALUout), .XM_BT(XM_BT), .XM_RD(XM_RD), .XM_MD(XM_MD)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        regwrite;
        logic        branch;
        logic [31:0] bt;
        logic        chk_bt;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Monitor: every valid XM word is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst && XM_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", {31'd0, XM_valid}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, "_alu"}, ALUout, e.alu);
                chk({e.name, "_rd"}, {27'd0, XM_RD}, {27'd0, e.rd});
                chk({e.name, "_regwrite"}, {31'd0, XM_RegWrite}, {31'd0, e.regwrite});
                chk({e.name, "_branch"}, {31'd0, XM_branch}, {31'd0, e.branch});
                if (e.chk_bt) chk({e.name, "_bt"}, XM_BT, e.bt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dx(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic rw, input logic br,
                          input logic [31:0] npc, input logic [15:0] im);
        DX_valid = 1'b1; ALUctr = op; A = a; B = b; DX_RD = rd; DX_RegWrite = rw;
        DX_branch = br; NPC = npc; imm = im; DX_MD = a ^ b;
    endtask

    task automatic push(input string name, input logic [31:0] alu, input logic [4:0] rd,
                        input logic rw, input logic br, input logic [31:0] bt, input logic cb);
        exp_t e;
        e.name = name; e.alu = alu; e.rd = rd; e.regwrite = rw;
        e.branch = br; e.bt = bt; e.chk_bt = cb;
        exp_q.push_back(e);
    endtask

    task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic rw,
                         input logic br, input logic [31:0] npc, input logic [15:0] im,
                         input logic [31:0] ealu, input logic ebr, input logic [31:0] ebt);
        set_dx(op, a, b, rd, rw, br, npc, im);
        push(name, ealu, rd, rw, ebr, ebt, 1'b1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("reset_valid", {31'd0, XM_valid}, 32'd0);
        chk("reset_busy", {31'd0, ex_busy}, 32'd0);
        chk("reset_ctrl", {27'd0, XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, XM_branch}, 32'd0);
        chk("reset_alu", ALUout, 32'd0);
        chk("reset_bt", XM_BT, 32'd0);
        chk("reset_rd_md", XM_MD | {27'd0, XM_RD}, 32'd0);

        issue("add",  4'd0,  32'd5,        32'd7,        5'd3, 1'b1, 1'b0, 32'h0,   16'h0,    32'd12,       1'b0, 32'h0);
        issue("slt",  4'd4,  32'hFFFFFFFF, 32'd1,        5'd1, 1'b1, 1'b0, 32'h40,  16'h1,    32'd1,        1'b0, 32'h44);
        issue("sltu", 4'd9,  32'hFFFFFFFF, 32'd1,        5'd2, 1'b1, 1'b0, 32'h40,  16'h1,    32'd0,        1'b0, 32'h44);
        issue("nor",  4'd7,  32'h0,        32'h0,        5'd4, 1'b1, 1'b0, 32'h0,   16'h0,    32'hFFFFFFFF, 1'b0, 32'h0);
        issue("beq",  4'd5,  32'd9,        32'd9,        5'd0, 1'b0, 1'b1, 32'h100, 16'hFFFF, 32'd0,        1'b1, 32'hFC);
        issue("bne",  4'd6,  32'd9,        32'd9,        5'd0, 1'b0, 1'b1, 32'h100, 16'hFFFF, 32'd0,        1'b0, 32'hFC);
        issue("sub",  4'd1,  32'd3,        32'd5,        5'd5, 1'b1, 1'b0, 32'h200, 16'h0010, 32'hFFFFFFFE, 1'b0, 32'h240);
        issue("xor",  4'd8,  32'h0000F0F0, 32'h0000FF00, 5'd6, 1'b1, 1'b0, 32'h0,   16'h0,    32'h00000FF0, 1'b0, 32'h0);
        issue("and",  4'd2,  32'hC,        32'hA,        5'd7, 1'b1, 1'b0, 32'h0,   16'h0,    32'h8,        1'b0, 32'h0);
        issue("or",   4'd3,  32'hC,        32'hA,        5'd7, 1'b1, 1'b0, 32'h0,   16'h0,    32'hE,        1'b0, 32'h0);
        issue("bad",  4'd15, 32'hC,        32'hA,        5'd9, 1'b1, 1'b0, 32'h0,   16'h0,    32'h0,        1'b0, 32'h0);
        issue("wrap", 4'd0,  32'hFFFFFFFF, 32'd2,        5'd3, 1'b1, 1'b0, 32'h0,   16'h0,    32'd1,        1'b0, 32'h0);

        // Multiply with an add held on DX throughout the busy window.
        set_dx(4'd10, 32'h00010003, 32'd7, 5'd8, 1'b1, 1'b0, 32'h0, 16'h0);
        push("mul", 32'h00070015, 5'd8, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        chk("mul_busy_start", {31'd0, ex_busy}, 32'd1);
        set_dx(4'd0, 32'd100, 32'd23, 5'd4, 1'b1, 1'b0, 32'h0, 16'h0);
        push("add_after_mul", 32'd123, 5'd4, 1'b1, 1'b0, 32'h0, 1'b1);
        n = 0;
        while (ex_busy && n < 100) begin
            n++;
            tick();
        end
        chk("mul_busy_cycles", n, 32'd32);
        tick();
        DX_valid = 1'b0;
        tick();
        chk("mul_queue_drained", exp_q.size(), 32'd0);

        // Flush a multiply in its 10th busy cycle.
        set_dx(4'd10, 32'd3, 32'd5, 5'd10, 1'b1, 1'b0, 32'h0, 16'h0);
        tick();
        DX_valid = 1'b0;
        repeat (9) tick();
        chk("flush_pre_busy", {31'd0, ex_busy}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", {31'd0, ex_busy}, 32'd0);
        chk("flush_valid", {31'd0, XM_valid}, 32'd0);
        chk("flush_alu_hold", ALUout, 32'd123);
        repeat (40) tick();

        // Flush on an incoming add produces a bubble.
        set_dx(4'd0, 32'd1, 32'd1, 5'd11, 1'b1, 1'b0, 32'h0, 16'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        DX_valid = 1'b0;
        chk("flush_add_valid", {31'd0, XM_valid}, 32'd0);
        chk("flush_add_regwrite", {31'd0, XM_RegWrite}, 32'd0);
        chk("flush_add_alu_hold", ALUout, 32'd123);

        // Asynchronous reset in the middle of a multiply.
        set_dx(4'd10, 32'd2, 32'd3, 5'd12, 1'b1, 1'b0, 32'h0, 16'h0);
        tick();
        DX_valid = 1'b0;
        repeat (4) tick();
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_busy", {31'd0, ex_busy}, 32'd0);
        chk("rst_mid_alu", ALUout, 32'd0);
        chk("rst_mid_valid_rd", {26'd0, XM_valid, XM_RD}, 32'd0);
        tick();
        rst = 1'b1;
        repeat (40) tick();
        chk("rst_mid_no_result", {31'd0, XM_valid}, 32'd0);
        issue("add_after_rst", 4'd0, 32'd1, 32'd1, 5'd2, 1'b1, 1'b0, 32'h8, 16'h2, 32'd2, 1'b0, 32'h10);
        DX_valid = 1'b0;
        repeat (3) tick();
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
